// File: rtl/keccak_rho_pi.sv
// Keccak rho (lane rotation) and optional pi (lane permutation) step unit.
// Processes LANES_PER_CYC lanes per RUN cycle and pulses valid when the full state is written.
module keccak_rho_pi #(
  parameter int LANE_W        = 64,
  parameter int LANES_PER_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pi_en,
  input  logic [25*LANE_W-1:0]  state_i,
  output logic [25*LANE_W-1:0]  state_o,
  output logic                  busy,
  output logic                  valid
);

  if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
    $error("keccak_rho_pi: LANE_W must be 8, 16, 32 or 64");
  end
  if (!(LANES_PER_CYC == 1 || LANES_PER_CYC == 5 || LANES_PER_CYC == 25)) begin : g_bad_lpc
    $error("keccak_rho_pi: LANES_PER_CYC must be 1, 5 or 25");
  end

  localparam logic [4:0] STEP     = 5'(LANES_PER_CYC);
  localparam logic [4:0] LAST_CNT = 5'(25 - LANES_PER_CYC);

  // Rotation offset for lane i = x+5y, reduced to the lane width.
  function automatic int unsigned rho_off(input int unsigned i);
    int unsigned r;
    case (i)
      0:  r = 0;   1:  r = 1;   2:  r = 62;  3:  r = 28;  4:  r = 27;
      5:  r = 36;  6:  r = 44;  7:  r = 6;   8:  r = 55;  9:  r = 20;
      10: r = 3;   11: r = 10;  12: r = 43;  13: r = 25;  14: r = 39;
      15: r = 41;  16: r = 45;  17: r = 15;  18: r = 21;  19: r = 8;
      20: r = 18;  21: r = 2;   22: r = 61;  23: r = 56;  24: r = 14;
      default: r = 0;
    endcase
    return r % LANE_W;
  endfunction

  // Destination of lane (x,y) under pi: (y, (2x+3y) mod 5).
  function automatic int unsigned pi_dst(input int unsigned i);
    int unsigned x, y;
    x = i % 5;
    y = i / 5;
    return y + 5 * ((2 * x + 3 * y) % 5);
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q;
  logic                pi_q;
  logic                valid_q;
  logic                accept;
  logic                last;
  logic [LANE_W-1:0]   lane_in  [25];
  logic [LANE_W-1:0]   lane_rot [25];
  logic [LANE_W-1:0]   lane_out [25];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy   = (state_q == RUN);
    accept = (state_q == IDLE) && start;
    last   = (state_q == RUN) && (cnt_q == LAST_CNT);
    valid  = valid_q;
  end

  // Fixed per-lane rotations; a shift by LANE_W yields zero, so offset 0 passes through.
  for (genvar g = 0; g < 25; g++) begin : g_rot
    localparam int unsigned R = rho_off(g);
    always_comb lane_rot[g] = (lane_in[g] << R) | (lane_in[g] >> (LANE_W - R));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pi_q    <= 1'b0;
      valid_q <= 1'b0;
      for (int unsigned j = 0; j < 25; j++) begin
        lane_in[j]  <= '0;
        lane_out[j] <= '0;
      end
    end else begin
      valid_q <= last;
      if (accept) begin
        cnt_q <= '0;
        pi_q  <= pi_en;
        for (int unsigned j = 0; j < 25; j++)
          lane_in[j] <= state_i[j*LANE_W +: LANE_W];
      end else if (busy) begin
        cnt_q <= last ? '0 : cnt_q + STEP;
        // Unrolled over all lanes; only those inside the current window are written.
        for (int unsigned j = 0; j < 25; j++) begin
          if (5'(j) >= cnt_q && 5'(j) < cnt_q + STEP)
            lane_out[pi_q ? 5'(pi_dst(j)) : 5'(j)] <= lane_rot[j];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < 25; j++)
      state_o[j*LANE_W +: LANE_W] = lane_out[j];
  end

endmodule

// File: tb/tb_keccak_rho_pi.sv
// Self-checking bench for keccak_rho_pi: three configurations checked against a bitwise rho/pi model.
module tb_keccak_rho_pi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 64-bit lanes, 1 lane per cycle
  logic          s1_start, s1_pi, s1_busy, s1_valid;
  logic [1599:0] s1_in, s1_out;
  // 8-bit lanes, 5 lanes per cycle
  logic          s5_start, s5_pi, s5_busy, s5_valid;
  logic [199:0]  s5_in, s5_out;
  // 64-bit lanes, 25 lanes per cycle
  logic          s25_start, s25_pi, s25_busy, s25_valid;
  logic [1599:0] s25_in, s25_out;

  keccak_rho_pi #(.LANE_W(64), .LANES_PER_CYC(1)) u1 (
    .clk(clk), .rst(rst), .start(s1_start), .pi_en(s1_pi), .state_i(s1_in),
    .state_o(s1_out), .busy(s1_busy), .valid(s1_valid));

  keccak_rho_pi #(.LANE_W(8), .LANES_PER_CYC(5)) u5 (
    .clk(clk), .rst(rst), .start(s5_start), .pi_en(s5_pi), .state_i(s5_in),
    .state_o(s5_out), .busy(s5_busy), .valid(s5_valid));

  keccak_rho_pi #(.LANE_W(64), .LANES_PER_CYC(25)) u25 (
    .clk(clk), .rst(rst), .start(s25_start), .pi_en(s25_pi), .state_i(s25_in),
    .state_o(s25_out), .busy(s25_busy), .valid(s25_valid));

  int tests = 0;
  int fails = 0;

  localparam int OFF [5][5] = '{
    '{0, 36, 3, 41, 18},
    '{1, 44, 10, 45, 2},
    '{62, 6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39, 8, 14}
  };

  // Bitwise model: A'[z] = A[(z - r) mod w], then optional move of (x,y) to (y, 2x+3y mod 5).
  function automatic logic [1599:0] ref_model(input logic [1599:0] a, input bit pi, input int w);
    logic [1599:0] r;
    int rr, dx, dy;
    r = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        rr = OFF[x][y] % w;
        if (pi) begin dx = y; dy = (2 * x + 3 * y) % 5; end
        else    begin dx = x; dy = y; end
        for (int z = 0; z < w; z++)
          r[(dx + 5 * dy) * w + z] = a[(x + 5 * y) * w + (z - rr + w) % w];
      end
    end
    return r;
  endfunction

  function automatic logic [1599:0] rnd_state();
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1599:0] obs, input logic [1599:0] exp, input int w);
    logic [63:0] lo, le;
    int idx;
    tests++;
    assert (obs === exp) else begin
      fails++;
      idx = 0;
      lo = '0;
      le = '0;
      for (int i = 24; i >= 0; i--) begin
        logic [63:0] a, b;
        a = 64'(obs >> (i * w));
        b = 64'(exp >> (i * w));
        if (w < 64) begin a &= (64'd1 << w) - 1; b &= (64'd1 << w) - 1; end
        if (a !== b) begin idx = i; lo = a; le = b; end
      end
      $error("FAIL %s lane %0d observed=%h expected=%h", tag, idx, lo, le);
    end
  endtask

  task automatic run1(input logic [1599:0] st, input bit pi, output int lat, output int bc);
    @(negedge clk);
    s1_in = st; s1_pi = pi; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    s1_in = rnd_state();
    lat = 1; bc = 0;
    while (lat < 60) begin
      if (s1_busy) bc++;
      @(posedge clk); #1;
      lat++;
      if (s1_valid) break;
    end
  endtask

  task automatic run5(input logic [199:0] st, input bit pi, output int lat);
    @(negedge clk);
    s5_in = st; s5_pi = pi; s5_start = 1'b1;
    @(posedge clk); #1;
    s5_start = 1'b0;
    s5_in = 200'(rnd_state());
    lat = 1;
    do begin @(posedge clk); #1; lat++; end while (!s5_valid && lat < 20);
  endtask

  initial begin
    logic [1599:0] st, a, b, cap;
    logic [199:0]  st5;
    bit pa, pb;
    int lat, bc, pulses;

    rst = 1'b1;
    s1_start = 0; s1_pi = 0; s1_in = '0;
    s5_start = 0; s5_pi = 0; s5_in = '0;
    s25_start = 0; s25_pi = 0; s25_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_int("reset_busy", int'(s1_busy), 0);
    chk_int("reset_valid", int'(s1_valid), 0);
    chk_state("reset_state", s1_out, '0, 64);
    chk_int("reset_valid_lpc25", int'(s25_valid), 0);
    @(negedge clk); rst = 1'b0;

    // Directed: lane(0,0)=0x8000000000000001, lane(1,0)=1, no pi
    st = '0;
    st[63:0]   = 64'h8000000000000001;
    st[127:64] = 64'h1;
    run1(st, 1'b0, lat, bc);
    chk_int("lpc1_latency", lat, 26);
    chk_int("lpc1_busy_cycles", bc, 25);
    chk_state("lpc1_rho_only", s1_out, ref_model(st, 1'b0, 64), 64);
    chk_int("lpc1_lane10_is_2", int'(s1_out[127:64] == 64'h2), 1);
    chk_int("lpc1_lane00_kept", int'(s1_out[63:0] == 64'h8000000000000001), 1);
    @(posedge clk); #1;
    chk_int("valid_one_cycle", int'(s1_valid), 0);

    // Same with pi
    run1(st, 1'b1, lat, bc);
    chk_int("lpc1_pi_latency", lat, 26);
    chk_state("lpc1_rho_pi", s1_out, ref_model(st, 1'b1, 64), 64);
    chk_int("lpc1_pi_lane02_is_2", int'(s1_out[10*64 +: 64] == 64'h2), 1);
    chk_int("lpc1_pi_lane10_zero", int'(s1_out[127:64] == 64'h0), 1);

    // Random jobs on the 1-lane unit
    for (int i = 0; i < 3; i++) begin
      st = rnd_state();
      pa = 1'($urandom());
      run1(st, pa, lat, bc);
      chk_int("lpc1_rand_latency", lat, 26);
      chk_state("lpc1_rand", s1_out, ref_model(st, pa, 64), 64);
    end

    // 8-bit lanes, 5 per cycle
    st5 = '0;
    st5[2*8 +: 8] = 8'h01;
    run5(st5, 1'b0, lat);
    chk_int("lpc5_latency", lat, 6);
    chk_int("lpc5_lane20_is_40", int'(s5_out[2*8 +: 8]), 'h40);
    chk_state("lpc5_directed", {1400'b0, s5_out}, ref_model({1400'b0, st5}, 1'b0, 8), 8);
    for (int i = 0; i < 2; i++) begin
      st5 = 200'(rnd_state());
      pa = 1'($urandom());
      run5(st5, pa, lat);
      chk_int("lpc5_rand_latency", lat, 6);
      chk_state("lpc5_rand", {1400'b0, s5_out}, ref_model({1400'b0, st5}, pa, 8), 8);
    end

    // 25 lanes per cycle, back-to-back jobs
    a = rnd_state(); b = rnd_state();
    pa = 1'($urandom()); pb = 1'($urandom());
    @(negedge clk);
    s25_in = a; s25_pi = pa; s25_start = 1'b1;
    @(posedge clk); #1;
    chk_int("lpc25_busy", int'(s25_busy), 1);
    @(negedge clk);
    s25_start = 1'b0; s25_in = rnd_state();
    lat = 1;
    do begin @(posedge clk); #1; lat++; end while (!s25_valid && lat < 10);
    chk_int("lpc25_latency", lat, 2);
    chk_state("lpc25_job_a", s25_out, ref_model(a, pa, 64), 64);
    chk_int("lpc25_busy_low_at_valid", int'(s25_busy), 0);
    @(negedge clk);
    s25_in = b; s25_pi = pb; s25_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    s25_start = 1'b0; s25_in = rnd_state();
    lat = 1;
    do begin @(posedge clk); #1; lat++; end while (!s25_valid && lat < 10);
    chk_int("lpc25_b2b_latency", lat, 2);
    chk_state("lpc25_job_b", s25_out, ref_model(b, pb, 64), 64);
    @(posedge clk); #1;
    chk_int("lpc25_valid_drop", int'(s25_valid), 0);

    // start during RUN is ignored
    a = rnd_state(); b = rnd_state();
    pa = 1'($urandom());
    @(negedge clk);
    s1_in = a; s1_pi = pa; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    s1_in = b; s1_pi = ~pa; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    pulses = 0; cap = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (s1_valid) begin
        pulses++;
        if (pulses == 1) cap = s1_out;
      end
    end
    chk_int("ignored_start_pulses", pulses, 1);
    chk_state("ignored_start_result", cap, ref_model(a, pa, 64), 64);

    // Reset in the middle of a job
    @(negedge clk);
    s1_in = rnd_state(); s1_pi = 1'b0; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_int("midrst_busy", int'(s1_busy), 0);
    chk_int("midrst_valid", int'(s1_valid), 0);
    chk_state("midrst_state", s1_out, '0, 64);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (s1_valid) pulses++;
    end
    chk_int("midrst_no_valid", pulses, 0);
    st = rnd_state();
    pa = 1'($urandom());
    run1(st, pa, lat, bc);
    chk_int("post_rst_latency", lat, 26);
    chk_state("post_rst_result", s1_out, ref_model(st, pa, 64), 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
